// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared definitions for the router memory-protocol port
//               handlers: address field widths, handler state encoding and
//               a helper that extracts the destination router field from a
//               network address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int ROUTER_ADDR_W = 4;
    localparam int MEM_ADDR_W    = 8;
    localparam int NET_ADDR_W    = 12;

    // Handler state; explicit 2-bit encoding keeps it compatible with
    // legacy code that compares against raw constants.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    // Network address layout: [11:8] destination router, [7:0] memory address.
    function automatic logic [ROUTER_ADDR_W-1:0] router_field(
        input logic [NET_ADDR_W-1:0] net_addr
    );
        return net_addr[NET_ADDR_W-1 -: ROUTER_ADDR_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/response_timer.sv
// ============================================================================
// Module      : response_timer
// Description : Saturating cycle counter used to time out read responses.
//               Counts while enabled, holds at TIMEOUT_CYCLES-1 (never wraps)
//               and flags expired while holding that value.
// Ports       : clk, reset (async, active-high)
//               clear   - synchronous clear to 0 (has priority over enable)
//               enable  - count one cycle
//               expired - counter is at TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module response_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != C_LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/outgoing_port_handler.sv
// ============================================================================
// Module      : outgoing_port_handler
// Description : Requester side of the router memory protocol. Accepts one
//               request at a time from the local core, tags it with the
//               local router address, presents it to the router until
//               netReady, then (for reads) waits for the matching response
//               with a timeout and returns the result to the core.
// Ports       : clk, reset (async, active-high), localRouterAddress
//               core request : coreReqValid/Ready/Write/Address/Data
//               router request: destinationAddressOut, requesterAddressOut,
//                               dataOut, readOut, writeOut, netReady
//               router response: respValid, respRequesterAddress, respData
//               core response : coreRespValid, coreRespData, coreRespError
//               status        : busy
// Config      : define OUTGOING_RETRY_EN to retry a read once after its
//               first timeout before reporting an error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module outgoing_port_handler
    import router_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROUTER_ADDR_W-1:0] localRouterAddress,
    input  logic                     coreReqValid,
    output logic                     coreReqReady,
    input  logic                     coreReqWrite,
    input  logic [NET_ADDR_W-1:0]    coreReqAddress,
    input  logic [DATA_WIDTH-1:0]    coreReqData,
    output logic [NET_ADDR_W-1:0]    destinationAddressOut,
    output logic [ROUTER_ADDR_W-1:0] requesterAddressOut,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     readOut,
    output logic                     writeOut,
    input  logic                     netReady,
    input  logic                     respValid,
    input  logic [ROUTER_ADDR_W-1:0] respRequesterAddress,
    input  logic [DATA_WIDTH-1:0]    respData,
    output logic                     coreRespValid,
    output logic [DATA_WIDTH-1:0]    coreRespData,
    output logic                     coreRespError,
    output logic                     busy
);

    state_t                   state_d,     state_q;
    logic [NET_ADDR_W-1:0]    dest_d,      dest_q;
    logic [ROUTER_ADDR_W-1:0] req_tag_d,   req_tag_q;
    logic [DATA_WIDTH-1:0]    data_d,      data_q;
    logic                     is_write_d,  is_write_q;
    logic                     rd_strb_d,   rd_strb_q;
    logic                     wr_strb_d,   wr_strb_q;
    logic                     resp_vld_d,  resp_vld_q;
    logic [DATA_WIDTH-1:0]    resp_data_d, resp_data_q;
    logic                     resp_err_d,  resp_err_q;
    logic                     busy_d,      busy_q;
`ifdef OUTGOING_RETRY_EN
    logic                     retry_d,     retry_q;
`endif

    logic timer_expired;
    logic resp_match;

    // Timer is held at zero outside WAIT_RESP, so every entry into
    // WAIT_RESP (including a retry) starts a fresh timeout window.
    response_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_response_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT_RESP),
        .enable  (state_q == WAIT_RESP),
        .expired (timer_expired)
    );

    assign resp_match = respValid && (respRequesterAddress == req_tag_q);

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        req_tag_d   = req_tag_q;
        data_d      = data_q;
        is_write_d  = is_write_q;
        rd_strb_d   = rd_strb_q;
        wr_strb_d   = wr_strb_q;
        resp_vld_d  = 1'b0;
        resp_data_d = '0;
        resp_err_d  = 1'b0;
`ifdef OUTGOING_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (coreReqValid) begin
                    dest_d     = coreReqAddress;
                    req_tag_d  = localRouterAddress;
                    data_d     = coreReqWrite ? coreReqData : '0;
                    is_write_d = coreReqWrite;
                    rd_strb_d  = !coreReqWrite;
                    wr_strb_d  = coreReqWrite;
                    state_d    = SEND;
`ifdef OUTGOING_RETRY_EN
                    retry_d    = 1'b0;
`endif
                end
            end

            SEND: begin
                if (netReady) begin
                    rd_strb_d = 1'b0;
                    wr_strb_d = 1'b0;
                    // Writes are posted: no response is expected.
                    state_d   = is_write_q ? IDLE : WAIT_RESP;
                end
            end

            WAIT_RESP: begin
                // A match takes priority over a timeout in the same cycle.
                if (resp_match) begin
                    resp_vld_d  = 1'b1;
                    resp_data_d = respData;
                    state_d     = IDLE;
                end else if (timer_expired) begin
`ifdef OUTGOING_RETRY_EN
                    if (!retry_q) begin
                        retry_d   = 1'b1;
                        rd_strb_d = 1'b1;
                        state_d   = SEND;
                    end else begin
                        resp_vld_d = 1'b1;
                        resp_err_d = 1'b1;
                        state_d    = IDLE;
                    end
`else
                    resp_vld_d = 1'b1;
                    resp_err_d = 1'b1;
                    state_d    = IDLE;
`endif
                end
            end

            default: begin
                rd_strb_d = 1'b0;
                wr_strb_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            req_tag_q   <= '0;
            data_q      <= '0;
            is_write_q  <= 1'b0;
            rd_strb_q   <= 1'b0;
            wr_strb_q   <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef OUTGOING_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            req_tag_q   <= req_tag_d;
            data_q      <= data_d;
            is_write_q  <= is_write_d;
            rd_strb_q   <= rd_strb_d;
            wr_strb_q   <= wr_strb_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            busy_q      <= busy_d;
`ifdef OUTGOING_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Ready is gated by reset so the core never sees ready while the
    // handler is held in reset.
    assign coreReqReady          = (state_q == IDLE) && !reset;
    assign destinationAddressOut = dest_q;
    assign requesterAddressOut   = req_tag_q;
    assign dataOut               = data_q;
    assign readOut               = rd_strb_q;
    assign writeOut              = wr_strb_q;
    assign coreRespValid         = resp_vld_q;
    assign coreRespData          = resp_data_q;
    assign coreRespError         = resp_err_q;
    assign busy                  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_outgoing_port_handler.sv
// ============================================================================
// Module      : tb_outgoing_port_handler
// Description : Self-checking bench for outgoing_port_handler. Directed
//               scenarios plus randomized transactions; expected behaviour
//               is derived per transaction from the response arrival cycle
//               relative to the timeout window. Honours OUTGOING_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_outgoing_port_handler;

    localparam int DW = 8;
    localparam int T  = 64;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    localRouterAddress = 4'h6;
    logic          coreReqValid = 1'b0;
    logic          coreReqReady;
    logic          coreReqWrite = 1'b0;
    logic [11:0]   coreReqAddress = '0;
    logic [DW-1:0] coreReqData = '0;
    logic [11:0]   destinationAddressOut;
    logic [3:0]    requesterAddressOut;
    logic [DW-1:0] dataOut;
    logic          readOut;
    logic          writeOut;
    logic          netReady = 1'b0;
    logic          respValid = 1'b0;
    logic [3:0]    respRequesterAddress = '0;
    logic [DW-1:0] respData = '0;
    logic          coreRespValid;
    logic [DW-1:0] coreRespData;
    logic          coreRespError;
    logic          busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] txn_tag;

    outgoing_port_handler #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .localRouterAddress    (localRouterAddress),
        .coreReqValid          (coreReqValid),
        .coreReqReady          (coreReqReady),
        .coreReqWrite          (coreReqWrite),
        .coreReqAddress        (coreReqAddress),
        .coreReqData           (coreReqData),
        .destinationAddressOut (destinationAddressOut),
        .requesterAddressOut   (requesterAddressOut),
        .dataOut               (dataOut),
        .readOut               (readOut),
        .writeOut              (writeOut),
        .netReady              (netReady),
        .respValid             (respValid),
        .respRequesterAddress  (respRequesterAddress),
        .respData              (respData),
        .coreRespValid         (coreRespValid),
        .coreRespData          (coreRespData),
        .coreRespError         (coreRespError),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Random response with a tag that never matches the active transaction.
    task automatic noise(input bit force_it);
        if (force_it || ($urandom_range(0, 5) == 0)) begin
            respValid            = 1'b1;
            respRequesterAddress = txn_tag ^ 4'($urandom_range(1, 15));
            respData             = DW'($urandom);
        end else begin
            respValid = 1'b0;
        end
    endtask

    // Request is presented; router withholds netReady for dly cycles.
    task automatic send_phase(input bit wr, input logic [11:0] a, input logic [DW-1:0] d, input int dly);
        for (int i = 0; i <= dly; i++) begin
            check_val("wr_strobe",   writeOut, wr);
            check_val("rd_strobe",   readOut, !wr);
            check_val("dest_addr",   destinationAddressOut, a);
            check_val("wdata",       dataOut, wr ? d : '0);
            check_val("req_tag",     requesterAddressOut, txn_tag);
            check_val("ready_busy",  coreReqReady, 0);
            check_val("pulse_send",  coreRespValid, 0);
            netReady = (i == dly);
            noise(1'b0);
            @(negedge clk);
        end
        netReady  = 1'b0;
        respValid = 1'b0;
        check_val("wr_drop", writeOut, 0);
        check_val("rd_drop", readOut, 0);
    endtask

    // Waiting window; matching response driven in window cycle k (k >= T: none).
    task automatic wait_phase(input int k, input logic [DW-1:0] rdat, input bit last, output bit timed_out);
        timed_out = 1'b0;
        for (int c = 0; c < T; c++) begin
            if (c == k) begin
                respValid            = 1'b1;
                respRequesterAddress = txn_tag;
                respData             = rdat;
            end else begin
                noise(c == 2);
            end
            @(negedge clk);
            respValid = 1'b0;
            if (c == k) begin
                check_val("resp_valid", coreRespValid, 1);
                check_val("resp_data",  coreRespData, rdat);
                check_val("resp_err",   coreRespError, 0);
                check_val("resp_busy",  busy, 0);
                check_val("resp_ready", coreReqReady, 1);
                break;
            end else if (c == T - 1) begin
                timed_out = 1'b1;
                if (last) begin
                    check_val("to_valid", coreRespValid, 1);
                    check_val("to_err",   coreRespError, 1);
                    check_val("to_data",  coreRespData, 0);
                    check_val("to_busy",  busy, 0);
                end else begin
                    check_val("retry_novalid", coreRespValid, 0);
                    check_val("retry_strobe",  readOut, 1);
                end
            end else begin
                check_val("wait_novalid", coreRespValid, 0);
                check_val("wait_busy",    busy, 1);
            end
        end
    endtask

    task automatic do_txn(input bit wr, input logic [11:0] a, input logic [DW-1:0] d, input int dly,
                          input int k, input logic [DW-1:0] rdat,
                          input int dly2, input int k2, input logic [DW-1:0] rdat2);
        bit to;
        bit last_first;
        check_val("ready_idle", coreReqReady, 1);
        txn_tag        = localRouterAddress;
        coreReqValid   = 1'b1;
        coreReqWrite   = wr;
        coreReqAddress = a;
        coreReqData    = d;
        @(negedge clk);
        // Scramble everything the handler should have latched.
        coreReqValid       = 1'b0;
        coreReqWrite       = 1'($urandom);
        coreReqAddress     = 12'($urandom);
        coreReqData        = DW'($urandom);
        localRouterAddress = 4'($urandom);
        check_val("busy_accept", busy, 1);
        send_phase(wr, a, d, dly);
        if (wr) begin
            check_val("wr_idle",    busy, 0);
            check_val("wr_nopulse", coreRespValid, 0);
            return;
        end
        check_val("rd_wait_busy", busy, 1);
`ifdef OUTGOING_RETRY_EN
        last_first = 1'b0;
`else
        last_first = 1'b1;
`endif
        wait_phase(k, rdat, last_first, to);
        if (to && !last_first) begin
            send_phase(1'b0, a, d, dly2);
            wait_phase(k2, rdat2, 1'b1, to);
        end
    endtask

    initial begin
        int r;
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", coreReqReady, 0);
        check_val("rst_busy",  busy, 0);
        check_val("rst_rd",    readOut, 0);
        check_val("rst_wr",    writeOut, 0);
        check_val("rst_dest",  destinationAddressOut, 0);
        check_val("rst_tag",   requesterAddressOut, 0);
        check_val("rst_data",  dataOut, 0);
        check_val("rst_valid", coreRespValid, 0);
        check_val("rst_err",   coreRespError, 0);
        check_val("rst_rdata", coreRespData, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", coreReqReady, 1);

        // Directed scenarios
        do_txn(1'b1, 12'h3A5, 8'h5C, 3, 0, 8'h00, 0, 0, 8'h00);
        do_txn(1'b0, 12'h2F0, 8'h00, 0, 5, 8'h99, 0, NEVER, 8'h00);
        do_txn(1'b0, 12'h123, 8'h00, 1, NEVER, 8'h00, 0, NEVER, 8'h00);
        do_txn(1'b0, 12'h456, 8'h00, 0, T - 1, 8'hA7, 0, T - 1, 8'hB8);
        // Destination is this node itself; still goes out to the router.
        do_txn(1'b0, {localRouterAddress, 8'h11}, 8'h00, 2, 0, 8'h3C, 0, NEVER, 8'h00);
`ifdef OUTGOING_RETRY_EN
        // Retry answered within the second window.
        do_txn(1'b0, 12'h789, 8'h00, 0, NEVER, 8'h00, 2, 4, 8'h42);
`endif

        // Reset while waiting for a response, then a late matching response.
        txn_tag        = localRouterAddress;
        coreReqValid   = 1'b1;
        coreReqWrite   = 1'b0;
        coreReqAddress = 12'h155;
        @(negedge clk);
        coreReqValid = 1'b0;
        netReady     = 1'b1;
        @(negedge clk);
        netReady = 1'b0;
        repeat (5) @(negedge clk);
        check_val("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_ready", coreReqReady, 0);
        check_val("mid_rst_busy",  busy, 0);
        check_val("mid_rst_rd",    readOut, 0);
        check_val("mid_rst_valid", coreRespValid, 0);
        @(negedge clk);
        reset                = 1'b0;
        respValid            = 1'b1;
        respRequesterAddress = txn_tag;
        respData             = 8'hEE;
        @(negedge clk);
        respValid = 1'b0;
        check_val("late_valid", coreRespValid, 0);
        @(negedge clk);
        check_val("late_valid2", coreRespValid, 0);
        check_val("late_ready",  coreReqReady, 1);
        check_val("late_busy",   busy, 0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 3);
            k = (r < 2) ? $urandom_range(0, T - 2) : ((r == 2) ? T - 1 : NEVER);
            do_txn(1'($urandom), 12'($urandom), DW'($urandom), $urandom_range(0, 4),
                   k, DW'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(0, T - 1) : NEVER, DW'($urandom));
            repeat ($urandom_range(0, 2)) begin
                noise(1'b0);
                @(negedge clk);
                respValid = 1'b0;
                check_val("gap_ready",   coreReqReady, 1);
                check_val("gap_nopulse", coreRespValid, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/outgoing_port_handler.md
Name: outgoing_port_handler

Overview:
- Requester side of the router memory protocol; counterpart to the incoming port handler that decodes destination address and read/write into a port select and memory strobes.
- Takes single memory requests from the local core and tags them with the local router address as requester.
- Drives the request into the local router with a ready handshake, then waits for the matching read response and returns it to the core with a timeout.

Parameters:
- DATA_WIDTH, 8: width of write data and read response data.
- TIMEOUT_CYCLES, 64: cycles spent in WAIT_RESP before a read is declared failed; must be at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- localRouterAddress  in  4  this node's router address; driven on requesterAddressOut.
- coreReqValid  in  1  core request valid.
- coreReqReady  out  1  handler can accept a request.
- coreReqWrite  in  1  1 = write, 0 = read.
- coreReqAddress  in  12  [11:8] destination router, [7:0] memory address.
- coreReqData  in  DATA_WIDTH  write data.
- destinationAddressOut  out  12  registered copy of coreReqAddress.
- requesterAddressOut  out  4  registered localRouterAddress at accept.
- dataOut  out  DATA_WIDTH  registered write data; 0 for reads.
- readOut  out  1  read request strobe to router.
- writeOut  out  1  write request strobe to router.
- netReady  in  1  router accepts the current request this cycle.
- respValid  in  1  read response present.
- respRequesterAddress  in  4  requester tag of the response.
- respData  in  DATA_WIDTH  response data.
- coreRespValid  out  1  one-cycle pulse: read completed or failed.
- coreRespData  out  DATA_WIDTH  read data; 0 on error.
- coreRespError  out  1  qualifies coreRespValid: timeout.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, timer 0, coreReqReady 0 while reset is asserted.
- All outputs are registered, except coreReqReady, which equals (state == IDLE).
- IDLE: coreReqReady = 1. On coreReqValid, latch address, data and write, and capture requesterAddressOut = localRouterAddress. Go to SEND.
- Request to strobe latency: 1 cycle. readOut/writeOut rise in the cycle after accept.
- SEND: exactly one of readOut/writeOut is high. The strobe and address/data are held stable until netReady is sampled high.
  - Write + netReady: drop strobe, go to IDLE. Writes are posted and produce no coreRespValid.
  - Read + netReady: drop strobe, clear timer, go to WAIT_RESP.
- WAIT_RESP: timer increments every cycle.
  - A response matches when respValid && respRequesterAddress == requesterAddressOut.
  - Match: next cycle coreRespValid = 1, coreRespData = respData, coreRespError = 0; go to IDLE.
  - Non-matching or unsolicited responses are ignored in every state.
  - Timer reaches TIMEOUT_CYCLES-1 with no match: coreRespValid = 1, coreRespError = 1, coreRespData = 0; go to IDLE.
  - Match and timeout in the same cycle: the match wins.
- Requests whose destination equals localRouterAddress are still sent to the router; loopback is the router's job.
- Only one transaction is in flight. No new request is accepted until the state returns to IDLE.
- The coreRespValid pulse cycle coincides with state IDLE, so a new request can be accepted in that same cycle.
- Reset mid-operation: return immediately to IDLE, drop strobes, no response pulse.

Optional Feature:
- Macro: OUTGOING_RETRY_EN.
- Defined: the first timeout of a read re-enters SEND with the same latched request (one retry, tracked by a 1-bit retry flag cleared on accept). An error is reported only on the second timeout. A match during the retry completes normally.
- Undefined: the first timeout reports the error; no retry flag is present.

Decomposition:
- Shared package router_pkg contains:
  - ROUTER_ADDR_W = 4, MEM_ADDR_W = 8, NET_ADDR_W = 12.
  - A state enum {IDLE, SEND, WAIT_RESP}.
  - A helper function extracting the router field [11:8].
- One natural sub-module: response_timer.
  - Parameter: TIMEOUT_CYCLES. Inputs: clear, enable. Output: expired.
  - Width is $clog2(TIMEOUT_CYCLES). It saturates and does not wrap.

Test Plan:
- Write, addr 0x3A5, data 0x5C, netReady low for 3 cycles then high -> writeOut held 4 cycles with stable address/data, requesterAddressOut = localRouterAddress, no coreRespValid, busy clears next cycle.
- Read to 0x2F0, netReady immediate, response with tag = local and data 0x99 after 5 cycles -> one coreRespValid pulse, data 0x99, error 0.
- Read, response arrives with wrong tag, then no further response -> wrong tag ignored; at TIMEOUT_CYCLES (64) error pulse with data 0.
- Read where the matching respValid lands on the timeout cycle -> data is returned and error is 0.
- Reset asserted while in WAIT_RESP, then a late matching response -> no coreRespValid, state IDLE, coreReqReady = 1 after reset deasserts.
- With OUTGOING_RETRY_EN defined, read with no response -> readOut reasserted after the first timeout, error only after 2×64 cycles. The same stimulus without the macro gives an error after 64 cycles.
